mem_boot_sequencer: RTL

Parametrised load-and-run controller that replaces hand-driven bench stimulus for the single-cycle datapath. It accepts a valid/ready stream of (channel, address, data) words and writes them into instruction or data memory through the external write ports while holding the datapath in test mode. On start it issues a datapath clear pulse, switches to normal mode and counts execution cycles until halt or timeout. It sits between a host/loader interface and the datapath's ext_* and test_normal inputs.

---
 rtl/mem_boot_if.sv | 31 +++
 rtl/mem_boot_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mem_boot_if.sv
// Load-word stream between a host loader and the boot sequencer.
// The host is the master and the sequencer is the slave.
interface mem_boot_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              ld_valid;
  logic              ld_ready;
  logic              ld_chan;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;

  modport master (
    output ld_valid,
    output ld_chan,
    output ld_addr,
    output ld_data,
    output ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_chan,
    input  ld_addr,
    input  ld_data,
    input  ld_last,
    output ld_ready
  );
endinterface

// File: rtl/mem_boot_sequencer.sv
// Loads instruction/data memory images, then clears the datapath and
// runs it until halt or a cycle limit, counting RUN cycles.
module mem_boot_sequencer #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int CLR_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              clr_n,
  mem_boot_if.slave         ld,
  input  logic              start,
  input  logic [CNT_W-1:0]  max_cycles,
  input  logic              flag_HLT,
  output logic              test_normal,
  output logic              ext_instr_we,
  output logic [ADDR_W-1:0] ext_instr_addr,
  output logic [DATA_W-1:0] ext_instr_data,
  output logic              ext_data_write_en,
  output logic [ADDR_W-1:0] ext_data_addr,
  output logic [DATA_W-1:0] ext_data_data,
  output logic              cpu_clr,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [ADDR_W-1:0] words_loaded
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOADED,
    S_CLEAR,
    S_RUN,
    S_HALTED,
    S_TIMED_OUT
  } state_e;

  state_e            state_q, state_d;
  logic [CLR_W-1:0]  clr_q, clr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] wl_q, wl_d;
  logic              ready_q, ready_d;
  logic              tn_q, tn_d;
  logic              cclr_q, cclr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              to_q, to_d;
  logic              iwe_q, iwe_d;
  logic              dwe_q, dwe_d;
  logic [ADDR_W-1:0] iaddr_q, iaddr_d;
  logic [DATA_W-1:0] idata_q, idata_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [DATA_W-1:0] ddata_q, ddata_d;
  logic              accept;
  logic              rerun_ok;

  assign accept   = ld.ld_valid & ready_q;
  assign rerun_ok = (state_q == S_HALTED) || (state_q == S_TIMED_OUT);
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    cnt_d   = cnt_q;
    wl_d    = wl_q;
    iwe_d   = 1'b0;
    dwe_d   = 1'b0;
    iaddr_d = iaddr_q;
    idata_d = idata_q;
    daddr_d = daddr_q;
    ddata_d = ddata_q;

    unique case (state_q)
      S_IDLE, S_LOAD, S_HALTED, S_TIMED_OUT: begin
        // a completed handshake always wins over start
        if (accept) begin
          state_d = ld.ld_last ? S_LOADED : S_LOAD;
          wl_d    = (state_q == S_LOAD) ? wl_q + 1'b1 : ADDR_W'(1);
        end else if (start && rerun_ok) begin
          state_d = S_CLEAR;
          clr_d   = '0;
          cnt_d   = '0;
        end
      end
      S_LOADED: begin
        if (start) begin
          state_d = S_CLEAR;
          clr_d   = '0;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        if (clr_q == CLR_LAST) state_d = S_RUN;
        else                   clr_d   = clr_q + 1'b1;
      end
      S_RUN: begin
        cnt_d = cnt_inc;
        if (flag_HLT) begin
          state_d = S_HALTED;
        end else if (max_cycles != '0 && cnt_inc == max_cycles) begin
          state_d = S_TIMED_OUT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      if (ld.ld_chan) begin
        dwe_d   = 1'b1;
        daddr_d = ld.ld_addr;
        ddata_d = ld.ld_data;
      end else begin
        iwe_d   = 1'b1;
        iaddr_d = ld.ld_addr;
        idata_d = ld.ld_data;
      end
    end

    ready_d = (state_d == S_IDLE) || (state_d == S_LOAD) ||
              (state_d == S_HALTED) || (state_d == S_TIMED_OUT);
    tn_d    = (state_d != S_RUN);
    cclr_d  = (state_d == S_CLEAR);
    busy_d  = (state_d == S_CLEAR) || (state_d == S_RUN);
    done_d  = (state_d == S_HALTED);
    to_d    = (state_d == S_TIMED_OUT);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      clr_q   <= '0;
      cnt_q   <= '0;
      wl_q    <= '0;
      ready_q <= 1'b1;
      tn_q    <= 1'b1;
      cclr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      iwe_q   <= 1'b0;
      dwe_q   <= 1'b0;
      iaddr_q <= '0;
      idata_q <= '0;
      daddr_q <= '0;
      ddata_q <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
      wl_q    <= wl_d;
      ready_q <= ready_d;
      tn_q    <= tn_d;
      cclr_q  <= cclr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      to_q    <= to_d;
      iwe_q   <= iwe_d;
      dwe_q   <= dwe_d;
      iaddr_q <= iaddr_d;
      idata_q <= idata_d;
      daddr_q <= daddr_d;
      ddata_q <= ddata_d;
    end
  end

  assign ld.ld_ready        = ready_q;
  assign test_normal        = tn_q;
  assign cpu_clr            = cclr_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign timeout            = to_q;
  assign cycle_count        = cnt_q;
  assign words_loaded       = wl_q;
  assign ext_instr_we       = iwe_q;
  assign ext_instr_addr     = iaddr_q;
  assign ext_instr_data     = idata_q;
  assign ext_data_write_en  = dwe_q;
  assign ext_data_addr      = daddr_q;
  assign ext_data_data      = ddata_q;

endmodule
